// File: rtl/div_seq.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake.
// A zero divisor short-cuts to an all-ones quotient with div_by_zero set.
`timescale 1ns/1ps

module div_seq #(
  parameter int size = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [size-1:0] dividend,
  input  logic [size-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [size-1:0] quotient,
  output logic [size-1:0] remainder,
  output logic            div_by_zero
);

  localparam int CW = (size > 1) ? $clog2(size) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t          state;
  logic [size-1:0] q_sh;
  logic [size-1:0] dvs;
  logic [size-1:0] dvd;
  logic [size:0]   r;
  logic [CW-1:0]   cnt;
  logic            zero_pend;

  logic [size:0]   r_shift;
  logic [size:0]   r_next;
  logic [size-1:0] q_next;
  logic            ge;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    r_shift = (r << 1) | {{size{1'b0}}, q_sh[size-1]};
    ge      = (r_shift >= {1'b0, dvs});
    r_next  = ge ? (r_shift - {1'b0, dvs}) : r_shift;
    q_next  = {q_sh[size-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      q_sh        <= '0;
      dvs         <= '0;
      dvd         <= '0;
      r           <= '0;
      cnt         <= '0;
      zero_pend   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN: begin
          done <= 1'b0;
          // A zero divisor spends its single busy cycle parked in FIN.
          if (state == FIN && zero_pend) begin
            quotient    <= '1;
            remainder   <= dvd;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            zero_pend   <= 1'b0;
          end else if (start) begin
            q_sh <= dividend;
            r    <= '0;
            cnt  <= '0;
            dvs  <= divisor;
            dvd  <= dividend;
            busy <= 1'b1;
            if (divisor == '0) begin
              zero_pend <= 1'b1;
              state     <= FIN;
            end else begin
              state <= RUN;
            end
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          q_sh <= q_next;
          r    <= r_next;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(size - 1)) begin
            quotient    <= q_next;
            remainder   <= r_next[size-1:0];
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= FIN;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed scenarios plus a randomized sweep
// against a plain-arithmetic reference model.
`timescale 1ns/1ps

module tb_div_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int total;
  int bad;

  div_seq #(.size(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the arithmetic definition of the result.
  function automatic void model(input int a, input int b,
                                output int q, output int r, output int z, output int lat);
    if (b == 0) begin
      q = 255; r = a; z = 1; lat = 1;
    end else begin
      q = a / b; r = a % b; z = 0; lat = 8;
    end
  endfunction

  // Issues one start pulse and waits (bounded) for done; all sampling on negedges.
  task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                         output int lat, output int busy_cycles,
                         output logic [7:0] q_mid, output bit to);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    q_mid       = quotient;
    lat         = 0;
    busy_cycles = 0;
    to          = 1'b0;
    while (done !== 1'b1) begin
      if (busy === 1'b1) busy_cycles++;
      if (lat >= 40) begin
        to = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    dividend = 8'd0;
    divisor = 8'd0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b q=%0d r=%0d z=%b expected all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, bc;
    logic [7:0] qm;
    bit to;
    run_div(8'd200, 8'd7, lat, bc, qm, to);
    total++;
    if (to) begin
      bad++;
      $display("FAIL basic_timeout: done never seen, expected within 8 cycles");
    end
    total++;
    if (lat != 8) begin
      bad++;
      $display("FAIL basic_latency: got %0d expected 8", lat);
    end
    total++;
    if (bc != 8) begin
      bad++;
      $display("FAIL basic_busy_cycles: got %0d expected 8", bc);
    end
    total++;
    if (quotient !== 8'd28 || remainder !== 8'd4 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL basic_result: got q=%0d r=%0d z=%b expected q=28 r=4 z=0",
               quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_done_pulse: got done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_corners();
    logic [7:0] av[3] = '{8'd255, 8'd5, 8'd255};
    logic [7:0] bv[3] = '{8'd1, 8'd9, 8'd255};
    logic [7:0] qv[3] = '{8'd255, 8'd0, 8'd1};
    logic [7:0] rv[3] = '{8'd0, 8'd5, 8'd0};
    int lat, bc;
    logic [7:0] qm;
    bit to;
    for (int i = 0; i < 3; i++) begin
      run_div(av[i], bv[i], lat, bc, qm, to);
      total++;
      if (to || quotient !== qv[i] || remainder !== rv[i]) begin
        bad++;
        $display("FAIL corner_%0d_%0d: got q=%0d r=%0d to=%b expected q=%0d r=%0d",
                 av[i], bv[i], quotient, remainder, to, qv[i], rv[i]);
      end
    end
  endtask

  task automatic test_zero();
    int lat, bc;
    logic [7:0] qm;
    bit to;
    run_div(8'd77, 8'd0, lat, bc, qm, to);
    total++;
    if (to || lat != 1) begin
      bad++;
      $display("FAIL zero_latency: got %0d (to=%b) expected 1", lat, to);
    end
    total++;
    if (quotient !== 8'd255 || remainder !== 8'd77 || div_by_zero !== 1'b1) begin
      bad++;
      $display("FAIL zero_result: got q=%0d r=%0d z=%b expected q=255 r=77 z=1",
               quotient, remainder, div_by_zero);
    end
    run_div(8'd10, 8'd3, lat, bc, qm, to);
    total++;
    if (qm !== 8'd255) begin
      bad++;
      $display("FAIL zero_hold: got q=%0d during next op expected 255", qm);
    end
    total++;
    if (to || quotient !== 8'd3 || remainder !== 8'd1 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL zero_clear: got q=%0d r=%0d z=%b expected q=3 r=1 z=0",
               quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_ignore_busy();
    int dones;
    logic [7:0] q_seen, r_seen;
    dones = 0;
    q_seen = 8'hxx;
    r_seen = 8'hxx;
    @(negedge clk);
    dividend = 8'd50;
    divisor  = 8'd6;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) begin
        dones++;
        q_seen = quotient;
        r_seen = remainder;
      end
      @(negedge clk);
    end
    total++;
    if (dones != 1) begin
      bad++;
      $display("FAIL busy_done_count: got %0d expected 1", dones);
    end
    total++;
    if (q_seen !== 8'd8 || r_seen !== 8'd2) begin
      bad++;
      $display("FAIL busy_result: got q=%0d r=%0d expected q=8 r=2", q_seen, r_seen);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    @(negedge clk);
    dividend = 8'd123;
    divisor  = 8'd10;
    start    = 1'b1;
    @(negedge clk);
    dividend = 8'd250;
    divisor  = 8'd11;
    k = 0;
    while (done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (done !== 1'b1 || quotient !== 8'd12 || remainder !== 8'd3) begin
      bad++;
      $display("FAIL b2b_first: got done=%b q=%0d r=%0d expected 1 12 3",
               done, quotient, remainder);
    end
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (k != 9) begin
      bad++;
      $display("FAIL b2b_spacing: got %0d cycles between dones expected 9", k);
    end
    total++;
    if (quotient !== 8'd22 || remainder !== 8'd8) begin
      bad++;
      $display("FAIL b2b_second: got q=%0d r=%0d expected q=22 r=8", quotient, remainder);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int dones, lat, bc;
    logic [7:0] qm;
    bit to;
    @(negedge clk);
    dividend = 8'd200;
    divisor  = 8'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
      bad++;
      $display("FAIL async_reset: got busy=%b done=%b q=%0d r=%0d z=%b expected all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    total++;
    if (dones != 0) begin
      bad++;
      $display("FAIL reset_abort: got %0d done pulses expected 0", dones);
    end
    run_div(8'd9, 8'd2, lat, bc, qm, to);
    total++;
    if (to || quotient !== 8'd4 || remainder !== 8'd1) begin
      bad++;
      $display("FAIL reset_recover: got q=%0d r=%0d expected q=4 r=1", quotient, remainder);
    end
  endtask

  task automatic test_random();
    int a, b, eq, er, ez, el, lat, bc, prev_q;
    logic [7:0] qm;
    bit to;
    prev_q = quotient;
    for (int i = 0; i < 300; i++) begin
      a = $urandom_range(0, 255);
      b = (i % 25 == 0) ? 0 : $urandom_range(0, 255);
      model(a, b, eq, er, ez, el);
      run_div(a[7:0], b[7:0], lat, bc, qm, to);
      total++;
      if (to || quotient !== eq[7:0] || remainder !== er[7:0] || div_by_zero !== ez[0]
          || lat != el || int'(qm) != prev_q) begin
        bad++;
        $display("FAIL rand_%0d_%0d: got q=%0d r=%0d z=%b lat=%0d held=%0d expected q=%0d r=%0d z=%0d lat=%0d held=%0d",
                 a, b, quotient, remainder, div_by_zero, lat, qm, eq, er, ez, el, prev_q);
      end
      prev_q = eq;
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_basic();
    test_corners();
    test_zero();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
